serial_deframer_32: RTL and testbench

SERIAL_DEFRAMER_32 -- requirements
Module: serial_deframer_32

---
 rtl/deframer_pkg.sv | 6 +
 rtl/sipo_window_32.sv | 16 +
 rtl/serial_deframer_32.sv | 98 +++++++++
 tb/tb_serial_deframer_32.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/deframer_pkg.sv
// deframer_pkg: shared word width, default sync pattern and deframer state encoding
package deframer_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] SYNC_DEFAULT = 32'h1ACF_FC1D;
  typedef enum logic [1:0] {HUNT = 2'd0, PAYLOAD = 2'd1, CHECK = 2'd2} state_t;
endpackage

// File: rtl/sipo_window_32.sv
// sipo_window_32: 32-bit serial-in/parallel-out window, newest bit at LSB (clk, rst, data in; window out)
module sipo_window_32
  import deframer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              data,
  output logic [WORD_W-1:0] window
);
  logic [WORD_W-1:0] r_win;
  always_ff @(posedge clk) begin
    if (rst) r_win <= '0;
    else     r_win <= {r_win[WORD_W-2:0], data};
  end
  assign window = r_win;
endmodule

// File: rtl/serial_deframer_32.sv
// serial_deframer_32: sync-word hunt/track deframer (in: clk, rst, data, resync; out: word, word_valid, frame_start, locked, sync_err, frame_cnt)
module serial_deframer_32
  import deframer_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD   = SYNC_DEFAULT,
  parameter int                FRAME_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data,
  input  logic              resync,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              frame_start,
  output logic              locked,
  output logic              sync_err,
  output logic [15:0]       frame_cnt
);
  logic [WORD_W-1:0] w_win;
  logic              w_hit, w_last, w_fdone;
  state_t            r_state;
  logic [4:0]        r_bit;
  logic [7:0]        r_wrd;
  logic [WORD_W-1:0] r_word;
  logic              r_wv, r_fs, r_locked, r_err;
  logic [15:0]       r_fcnt;
  sipo_window_32 u_win (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .window (w_win)
  );
  assign w_hit   = w_win == SYNC_WORD;
  assign w_last  = r_bit == 5'd31;
  assign w_fdone = r_wrd == 8'(FRAME_WORDS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= HUNT;
      r_bit    <= '0;
      r_wrd    <= '0;
      r_word   <= '0;
      r_wv     <= 1'b0;
      r_fs     <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_wv  <= 1'b0;
      r_fs  <= 1'b0;
      r_err <= 1'b0;
      if (resync) begin
        r_state  <= HUNT;
        r_bit    <= '0;
        r_wrd    <= '0;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          HUNT: if (w_hit) begin
            r_state  <= PAYLOAD;
            r_locked <= 1'b1;
            r_fcnt   <= r_fcnt + 16'd1;
            r_bit    <= '0;
            r_wrd    <= '0;
          end
          PAYLOAD: begin
            r_bit <= r_bit + 5'd1;
            if (w_last) begin
              r_word <= w_win;
              r_wv   <= 1'b1;
              r_fs   <= r_wrd == 8'd0;
              r_wrd  <= w_fdone ? 8'd0 : r_wrd + 8'd1;
              if (w_fdone) r_state <= CHECK;
            end
          end
          CHECK: begin
            r_bit <= r_bit + 5'd1;
            if (w_last) begin
              r_state  <= w_hit ? PAYLOAD : HUNT;
              r_locked <= w_hit;
              r_err    <= !w_hit;
              if (w_hit) r_fcnt <= r_fcnt + 16'd1;
            end
          end
          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end
  assign word        = r_word;
  assign word_valid  = r_wv;
  assign frame_start = r_fs;
  assign locked      = r_locked;
  assign sync_err    = r_err;
  assign frame_cnt   = r_fcnt;
endmodule

// File: tb/tb_serial_deframer_32.sv
// tb_serial_deframer_32: scoreboard bench for serial_deframer_32
module tb_serial_deframer_32;
  localparam logic [31:0] SYNC = 32'h1ACF_FC1D;
  localparam logic [31:0] BAD  = 32'h1ACF_FC1C;
  logic        clk = 1'b0, rst = 1'b1, data = 1'b0, resync = 1'b0;
  logic [31:0] word;
  logic        word_valid, frame_start, locked, sync_err;
  logic [15:0] frame_cnt;
  typedef struct {
    logic [31:0] w;
    logic        fs;
    logic [15:0] fc;
    int unsigned cyc;
  } exp_t;
  exp_t        q[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          n_chk = 0, n_pass = 0, wv_cnt = 0, err_cnt = 0;
  bit          lock_watch = 1'b0;
  logic [31:0] f [4];
  serial_deframer_32 dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .resync      (resync),
    .word        (word),
    .word_valid  (word_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_err    (sync_err),
    .frame_cnt   (frame_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask
  always @(negedge clk) begin
    if (word_valid) begin
      wv_cnt++;
      if (q.size() == 0) chk("wv_unexpected", 64'(1), 64'(0));
      else begin
        e = q.pop_front();
        chk("word", 64'(word), 64'(e.w));
        chk("frame_start", 64'(frame_start), 64'(e.fs));
        chk("frame_cnt_at_word", 64'(frame_cnt), 64'(e.fc));
        chk("word_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (sync_err) err_cnt++;
    if (lock_watch) chk("locked_hold", 64'(locked), 64'(1));
  end
  task automatic drive_bit(input logic b);
    @(negedge clk);
    data = b;
  endtask
  task automatic send(input logic [31:0] w, input bit exp, input bit fs, input logic [15:0] fc);
    for (int i = 31; i >= 0; i--) drive_bit(w[i]);
    if (exp) q.push_back('{w: w, fs: fs, fc: fc, cyc: cyc + 2});
  endtask
  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0);
  endtask
  task automatic check_all_zero(input string tag);
    chk({tag, "_word"}, 64'(word), 64'(0));
    chk({tag, "_wv"}, 64'(word_valid), 64'(0));
    chk({tag, "_fs"}, 64'(frame_start), 64'(0));
    chk({tag, "_locked"}, 64'(locked), 64'(0));
    chk({tag, "_err"}, 64'(sync_err), 64'(0));
    chk({tag, "_fcnt"}, 64'(frame_cnt), 64'(0));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    zeros(200);
    @(negedge clk);
    chk("idle_locked", 64'(locked), 64'(0));
    chk("idle_wv", 64'(wv_cnt), 64'(0));
    chk("idle_err", 64'(err_cnt), 64'(0));
    f = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h00000001};
    send(SYNC, 0, 0, 0);
    send(f[0], 1, 1, 16'd1);
    lock_watch = 1'b1;
    for (int i = 1; i < 4; i++) send(f[i], 1, 0, 16'd1);
    chk("lock_fcnt", 64'(frame_cnt), 64'(1));
    f = '{32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, SYNC};
    send(SYNC, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(f[i], 1, i == 0, 16'd2);
    chk("cont_fcnt", 64'(frame_cnt), 64'(2));
    send(BAD, 0, 0, 0);
    lock_watch = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bad_err", 64'(sync_err), 64'(1));
    chk("bad_locked", 64'(locked), 64'(0));
    @(negedge clk);
    chk("bad_err_once", 64'(sync_err), 64'(0));
    chk("bad_err_cnt", 64'(err_cnt), 64'(1));
    zeros(40);
    send(SYNC, 0, 0, 0);
    for (int i = 0; i < 4; i++) send($urandom, 1, i == 0, 16'd3);
    chk("relock_fcnt", 64'(frame_cnt), 64'(3));
    send(SYNC, 0, 0, 0);
    send(32'h0F0F1234, 1, 1, 16'd4);
    send(32'h55AA33CC, 1, 0, 16'd4);
    send(32'hC0FFEE00, 0, 0, 0);
    drive_bit(1'b0);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    chk("coll_locked", 64'(locked), 64'(0));
    chk("coll_fcnt", 64'(frame_cnt), 64'(4));
    zeros(40);
    send(SYNC, 0, 0, 0);
    drive_bit(1'b0);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    chk("hunt_rs_locked", 64'(locked), 64'(0));
    chk("hunt_rs_fcnt", 64'(frame_cnt), 64'(4));
    zeros(40);
    send(SYNC, 0, 0, 0);
    send(32'h2468ACE0, 1, 1, 16'd5);
    f[0] = 32'h13579BDF;
    for (int i = 31; i >= 15; i--) drive_bit(f[0][i]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    f = '{32'hCAFEF00D, 32'h80000000, 32'h7FFFFFFF, 32'h3C3C3C3C};
    send(SYNC, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(f[i], 1, i == 0, 16'd1);
    repeat (3) @(negedge clk);
    chk("final_fcnt", 64'(frame_cnt), 64'(1));
    chk("final_err_cnt", 64'(err_cnt), 64'(1));
    chk("sb_empty", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
